led_effects_driver: RTL and testbench
=====================================

// Module: led_effects_driver
// PURPOSE
//  Downstream consumer of the LED PIO output port. Takes the NUM_LEDS-bit
//  software LED request vector and drives the physical LED pins.
//  Per-LED mode: pass-through, blink, PWM-dim or force-off.
//  Blink period, PWM duty and per-LED modes sit in a small Avalon-MM slave
//  register file on the same clock as the PIO.
// PARAMETERS
//  NUM_LEDS    4   width of led_in/led_out; CTRL uses 2*NUM_LEDS bits
//  DIV_W       24  width of blink divider register and prescaler counter
//  DUTY_W      8   width of PWM duty register and free-running PWM counter
// PORTS
//  clk         in   1           system clock; only clock in the block
//  reset_n     in   1           synchronous, active-low reset
//  address     in   2           Avalon-MM word address
//  chipselect  in   1           Avalon-MM select
//  write_n     in   1           Avalon-MM write strobe, active-low
//  writedata   in   32          Avalon-MM write data
//  readdata    out  32          Avalon-MM read data, combinational, zero-extended
//  led_in      in   NUM_LEDS    LED request vector from the PIO out_port
//  led_out     out  NUM_LEDS    registered LED pin drive, 1 = LED on
// BEHAVIOUR
//  Register map (write = chipselect & ~write_n; address selects the register):
//   0 CTRL   [2N-1:0]    RW  mode of LED i at bits [2i+1:2i]
//                            00 follow, 01 blink, 10 pwm, 11 off
//   1 DIV    [DIV_W-1:0] RW  blink half-period minus 1, in clk cycles
//   2 DUTY   [DUTY_W-1:0] RW PWM on-count per 2^DUTY_W cycles
//   3 STATUS             RO  bit0 blink_phase; bits[4+N-1:4] led_out
//                            writes to STATUS are ignored
//  Reset values: CTRL=0, DIV=0, DUTY=0x80, prescaler=0, blink_phase=0,
//   pwm_cnt=0, led_out=0. readdata follows address/registers combinationally.
//  Reset is synchronous: asserting reset_n mid-operation clears all state at
//   the next clk edge; no partial effect of a same-cycle write.
//  Prescaler:
//   - DIV==0: counter held at 0, no tick, blink_phase frozen.
//   - DIV!=0: count 0..DIV; at count==DIV wrap to 0, pulse tick,
//     toggle blink_phase. Half-period = DIV+1 cycles.
//  Write to DIV: loads new value, forces counter=0 and blink_phase=0 on the
//   same edge. This wins over a tick occurring in the same cycle.
//  PWM:
//   - pwm_cnt free-runs with wrap-around at 2^DUTY_W.
//   - pwm_on = (pwm_cnt < DUTY).
//   - DUTY=0 means never on; DUTY=2^DUTY_W-1 means on for all but one cycle.
//  Output select, per LED i, registered to led_out[i] (latency 1 clk from
//   led_in, CTRL or phase change):
//   - 00 -> led_in[i]
//   - 01 -> led_in[i] & blink_phase
//   - 10 -> led_in[i] & pwm_on
//   - 11 -> 0
//  CTRL write takes effect on led_out one cycle after the write edge.
//  led_in is synchronous to clk (from the PIO); no input synchronizer.
// STRUCTURE
//  Shared package: mode encodings (MODE_FOLLOW/BLINK/PWM/OFF) and register
//   addresses (ADDR_CTRL/DIV/DUTY/STATUS), for reuse by the firmware header.
//  One sub-module: led_tick_prescaler (DIV register compare, counter,
//   tick, blink_phase, load/clear on DIV write).
//  Register file, PWM counter and output mux stay in the top.
// TESTING
//  1 Reset: hold reset_n=0 two cycles with led_in=F, stray write
//    -> led_out=0; reads CTRL=0, DIV=0, DUTY=0x80, STATUS=0.
//  2 Follow: CTRL=0, led_in 0->4'b1010
//    -> led_out=4'b1010 exactly one clk later.
//  3 Blink: DIV=3, CTRL=0x55, led_in=F
//    -> led_out 0 for 4 cycles, then F for 4 cycles, repeating.
//    DIV rewrite mid-period -> phase 0, count restarts.
//  4 PWM: DUTY=64, CTRL=0x02, led_in=1
//    -> led_out[0] high exactly 64 of every 256 cycles.
//    DUTY=0 -> never high.
//  5 Off and collision: CTRL=0xFF, led_in=F -> led_out=0.
//    DIV write on a tick cycle -> blink_phase=0, counter=0.
//  6 Reset mid-blink with blink_phase=1 -> next edge led_out=0, phase 0,
//    all registers back to defaults.

Source files
------------

// File: rtl/led_effects_pkg.sv
// Shared definitions for the LED effects driver: mode encodings, register
// addresses and the per-LED output select rule.
package led_effects_pkg;

   localparam int unsigned ADDR_W         = 2;
   localparam int unsigned DATA_W         = 32;
   localparam int unsigned STATUS_LED_LSB = 4;

   typedef enum logic [1:0] {
      MODE_FOLLOW = 2'b00,
      MODE_BLINK  = 2'b01,
      MODE_PWM    = 2'b10,
      MODE_OFF    = 2'b11
   } led_mode_e;

   localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
   localparam logic [ADDR_W-1:0] ADDR_DIV    = 2'd1;
   localparam logic [ADDR_W-1:0] ADDR_DUTY   = 2'd2;
   localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd3;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } reg_wr_t;

   // Pin drive for one LED given its mode and the shared effect sources.
   function automatic logic led_select(input led_mode_e mode, input logic req,
                                       input logic phase, input logic pwm_on);
      logic drive;
      drive = 1'b0;
      case (mode)
         MODE_FOLLOW: drive = req;
         MODE_BLINK:  drive = req & phase;
         MODE_PWM:    drive = req & pwm_on;
         default:     drive = 1'b0;
      endcase
      return drive;
   endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Blink time base: holds the DIV register, counts 0..DIV and toggles
// blink_phase on every wrap. A DIV write restarts the period from phase 0.
module led_tick_prescaler
   import led_effects_pkg::*;
#(
   parameter int unsigned DIV_W = 24
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             div_we,
   input  logic [DIV_W-1:0] div_wdata,
   output logic [DIV_W-1:0] div_value,
   output logic             blink_phase
);

   logic [DIV_W-1:0] div_q,   div_d;
   logic [DIV_W-1:0] cnt_q,   cnt_d;
   logic             phase_q, phase_d;
   logic             tick_c;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         div_q   <= '0;
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   // DIV==0 freezes the counter; a DIV write overrides a coincident tick.
   always_comb begin
      div_d   = div_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      tick_c  = (div_q != '0) && (cnt_q == div_q);
      if (tick_c) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else if (div_q != '0) begin
         cnt_d = cnt_q + DIV_W'(1);
      end
      if (div_we) begin
         div_d   = div_wdata;
         cnt_d   = '0;
         phase_d = 1'b0;
      end
   end

   assign div_value   = div_q;
   assign blink_phase = phase_q;

endmodule

// File: rtl/led_effects_driver.sv
// LED pin driver behind the PIO: per-LED follow/blink/PWM/off selection,
// configured through a four-word Avalon-MM register file.
module led_effects_driver
   import led_effects_pkg::*;
#(
   parameter int unsigned NUM_LEDS = 4,
   parameter int unsigned DIV_W    = 24,
   parameter int unsigned DUTY_W   = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   address,
   input  logic                chipselect,
   input  logic                write_n,
   input  logic [DATA_W-1:0]   writedata,
   output logic [DATA_W-1:0]   readdata,
   input  logic [NUM_LEDS-1:0] led_in,
   output logic [NUM_LEDS-1:0] led_out
);

   localparam int unsigned CTRL_W = 2 * NUM_LEDS;
   localparam logic [DUTY_W-1:0] DUTY_RST = {1'b1, {(DUTY_W-1){1'b0}}};

   reg_wr_t             wr_c;
   logic [CTRL_W-1:0]   ctrl_q,    ctrl_d;
   logic [DUTY_W-1:0]   duty_q,    duty_d;
   logic [DUTY_W-1:0]   pwm_cnt_q, pwm_cnt_d;
   logic [NUM_LEDS-1:0] led_out_q, led_out_d;
   logic                div_we_c;
   logic                pwm_on_c;
   logic [DIV_W-1:0]    div_value;
   logic                blink_phase;
   logic                unused_wdata;

   assign wr_c.we      = chipselect & ~write_n;
   assign wr_c.addr    = address;
   assign wr_c.data    = writedata;
   assign unused_wdata = ^writedata;

   led_tick_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .clk         (clk),
      .reset_n     (reset_n),
      .div_we      (div_we_c),
      .div_wdata   (wr_c.data[DIV_W-1:0]),
      .div_value   (div_value),
      .blink_phase (blink_phase)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ctrl_q    <= '0;
         duty_q    <= DUTY_RST;
         pwm_cnt_q <= '0;
         led_out_q <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         duty_q    <= duty_d;
         pwm_cnt_q <= pwm_cnt_d;
         led_out_q <= led_out_d;
      end
   end

   // Register writes, PWM time base and per-LED output select.
   always_comb begin
      ctrl_d    = ctrl_q;
      duty_d    = duty_q;
      div_we_c  = 1'b0;
      pwm_cnt_d = pwm_cnt_q + DUTY_W'(1);
      pwm_on_c  = (pwm_cnt_q < duty_q);
      led_out_d = '0;
      if (wr_c.we) begin
         case (wr_c.addr)
            ADDR_CTRL: ctrl_d   = wr_c.data[CTRL_W-1:0];
            ADDR_DIV:  div_we_c = 1'b1;
            ADDR_DUTY: duty_d   = wr_c.data[DUTY_W-1:0];
            default:   ;
         endcase
      end
      for (int i = 0; i < NUM_LEDS; i++) begin
         led_out_d[i] = led_select(led_mode_e'(ctrl_q[2*i +: 2]), led_in[i],
                                   blink_phase, pwm_on_c);
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_CTRL:   readdata = DATA_W'(ctrl_q);
         ADDR_DIV:    readdata = DATA_W'(div_value);
         ADDR_DUTY:   readdata = DATA_W'(duty_q);
         ADDR_STATUS: readdata = DATA_W'({led_out_q, 3'b000, blink_phase});
         default:     readdata = '0;
      endcase
   end

   assign led_out = led_out_q;

endmodule

// File: tb/tb_led_effects_driver.sv
// Self-checking bench for led_effects_driver: hand vectors, corner sequences
// and random traffic against a time-based reference model.
module tb_led_effects_driver;
   import led_effects_pkg::*;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [3:0]  led_in;
   logic [3:0]  led_out;

   int checks = 0;
   int errors = 0;

   // Reference model state: registers plus elapsed-time counters.
   logic [7:0]  m_ctrl;
   int unsigned m_div;
   int unsigned m_duty;
   int unsigned m_cyc;
   int unsigned m_div_t;
   logic [3:0]  m_led;

   typedef struct {
      logic        rst_n;
      logic        cs;
      logic        wr_n;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  li;
      logic [3:0]  exp_led;
   } vec_t;

   vec_t vecs [13];

   led_effects_driver #(
      .NUM_LEDS (4),
      .DIV_W    (24),
      .DUTY_W   (8)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .led_in     (led_in),
      .led_out    (led_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic m_phase();
      if (m_div == 0) return 1'b0;
      return ((m_div_t / (m_div + 1)) % 2) == 1;
   endfunction

   task automatic model_edge(input logic rst_n, input logic cs, input logic wr_n,
                             input logic [1:0] a, input logic [31:0] d, input logic [3:0] li);
      logic       ph;
      logic       pw;
      logic [1:0] md;
      if (!rst_n) begin
         m_ctrl = '0; m_div = 0; m_duty = 128; m_cyc = 0; m_div_t = 0; m_led = '0;
      end else begin
         ph = m_phase();
         pw = (m_cyc % 256) < m_duty;
         for (int i = 0; i < 4; i++) begin
            md = m_ctrl[2*i +: 2];
            case (md)
               2'b00:   m_led[i] = li[i];
               2'b01:   m_led[i] = li[i] & ph;
               2'b10:   m_led[i] = li[i] & pw;
               default: m_led[i] = 1'b0;
            endcase
         end
         m_cyc++;
         m_div_t++;
         if (cs && !wr_n) begin
            case (a)
               2'd0: m_ctrl = d[7:0];
               2'd1: begin m_div = d[23:0]; m_div_t = 0; end
               2'd2: m_duty = d[7:0];
               default: ;
            endcase
         end
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, compare led_out.
   task automatic step(input logic rst_n, input logic cs, input logic wr_n,
                       input logic [1:0] a, input logic [31:0] d, input logic [3:0] li);
      reset_n    = rst_n;
      chipselect = cs;
      write_n    = wr_n;
      address    = a;
      writedata  = d;
      led_in     = li;
      @(posedge clk);
      model_edge(rst_n, cs, wr_n, a, d, li);
      #1;
      chk("led_out_model", {28'd0, led_out}, {28'd0, m_led});
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic idle(input logic [3:0] li);
      step(1'b1, 1'b0, 1'b1, 2'd0, 32'd0, li);
   endtask

   task automatic check_regs(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
      logic [31:0] exp [4];
      exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
      for (int a = 0; a < 4; a++) begin
         chipselect = 1'b1;
         write_n    = 1'b1;
         address    = 2'(a);
         #1;
         chk($sformatf("%s_rd%0d", tag, a), readdata, exp[a]);
      end
      chipselect = 1'b0;
   endtask

   task automatic check_regs_model(input string tag);
      check_regs(tag, {24'd0, m_ctrl}, m_div, m_duty,
                 {24'd0, m_led, 3'b000, m_phase()});
   endtask

   task automatic check_phase(input string tag, input logic exp);
      address    = ADDR_STATUS;
      chipselect = 1'b1;
      #1;
      chk(tag, {31'd0, readdata[0]}, {31'd0, exp});
      chipselect = 1'b0;
   endtask

   initial begin
      int cnt;
      logic        r_rst, r_cs, r_wr;
      logic [1:0]  r_a;
      logic [31:0] r_d;

      reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      address = '0; writedata = '0; led_in = '0;
      m_ctrl = '0; m_div = 0; m_duty = 128; m_cyc = 0; m_div_t = 0; m_led = '0;

      //             rst  cs   wr_n addr   wdata          li     exp
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_00FF, 4'hF, 4'h0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_00FF, 4'hF, 4'h0};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 2'd0, 32'h0000_0000, 4'h0, 4'h0};
      vecs[3]  = '{1'b1, 1'b0, 1'b1, 2'd0, 32'h0000_0000, 4'hA, 4'hA};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 2'd0, 32'h0000_0000, 4'h5, 4'h5};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 2'd0, 32'h0000_00FF, 4'hF, 4'hF};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, 2'd0, 32'h0000_0000, 4'hF, 4'h0};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 2'd0, 32'h0000_00C0, 4'hF, 4'h0};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 2'd0, 32'h0000_0000, 4'hF, 4'h7};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0000, 4'hF, 4'h7};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF, 4'hC, 4'h4};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'h0000_0000, 4'h3, 4'h3};
      vecs[12] = '{1'b1, 1'b0, 1'b1, 2'd0, 32'h0000_0000, 4'hC, 4'hC};

      for (int i = 0; i < 13; i++) begin
         step(vecs[i].rst_n, vecs[i].cs, vecs[i].wr_n, vecs[i].addr, vecs[i].wdata, vecs[i].li);
         chk($sformatf("vec%0d", i), {28'd0, led_out}, {28'd0, vecs[i].exp_led});
         if (i == 1) check_regs("reset", 32'h0, 32'h0, 32'h80, 32'h0);
         if (i == 10) check_regs_model("status_wr");
      end

      // Blink with DIV=3: four cycles dark, four lit, repeating.
      step(1'b1, 1'b1, 1'b0, ADDR_CTRL, 32'h55, 4'hF);
      step(1'b1, 1'b1, 1'b0, ADDR_DIV, 32'd3, 4'hF);
      for (int k = 1; k <= 14; k++) begin
         idle(4'hF);
         chk($sformatf("blink_k%0d", k), {28'd0, led_out},
             (((k - 1) / 4) % 2 == 1) ? 32'hF : 32'h0);
      end
      // Mid-period DIV rewrite while lit: phase returns to 0, period restarts.
      step(1'b1, 1'b1, 1'b0, ADDR_DIV, 32'd3, 4'hF);
      chk("rewrite_edge", {28'd0, led_out}, 32'hF);
      check_phase("rewrite_phase", 1'b0);
      for (int k = 1; k <= 3; k++) begin
         idle(4'hF);
         chk($sformatf("rewrite_k%0d", k), {28'd0, led_out}, 32'h0);
      end
      // DIV write on the tick cycle: the write wins, phase stays 0.
      step(1'b1, 1'b1, 1'b0, ADDR_DIV, 32'd3, 4'hF);
      check_phase("collide_phase", 1'b0);
      check_regs_model("collide");
      for (int k = 1; k <= 5; k++) begin
         idle(4'hF);
         chk($sformatf("collide_k%0d", k), {28'd0, led_out}, (k == 5) ? 32'hF : 32'h0);
      end
      check_phase("pre_reset_phase", 1'b1);
      // Reset mid-blink with a stray write in the same cycle.
      step(1'b0, 1'b1, 1'b0, ADDR_CTRL, 32'hFF, 4'hF);
      chk("midreset_led", {28'd0, led_out}, 32'h0);
      check_regs("midreset", 32'h0, 32'h0, 32'h80, 32'h0);

      // PWM duty sweep on LED0.
      step(1'b1, 1'b1, 1'b0, ADDR_CTRL, 32'h02, 4'h1);
      for (int t = 0; t < 3; t++) begin
         logic [31:0] duty;
         duty = (t == 0) ? 32'd64 : (t == 1) ? 32'd0 : 32'd255;
         step(1'b1, 1'b1, 1'b0, ADDR_DUTY, duty, 4'h1);
         cnt = 0;
         for (int c = 0; c < 256; c++) begin
            idle(4'h1);
            if (led_out[0]) cnt++;
         end
         chk($sformatf("pwm_duty%0d", duty), 32'(cnt), duty);
      end

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         r_rst = ($urandom_range(0, 199) != 0);
         r_wr  = ($urandom_range(0, 7) == 0);
         r_cs  = r_wr ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
         r_a   = 2'($urandom_range(0, 3));
         r_d   = (r_a == ADDR_DIV) ? 32'($urandom_range(0, 5)) : $urandom;
         step(r_rst, r_cs, !r_wr, r_a, r_d, 4'($urandom_range(0, 15)));
         if (n % 50 == 49) check_regs_model($sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
